// File: rtl/sdram_wb_arbiter.sv
// Round-robin arbiter serialising single-beat reads/writes from NUM_REQ masters onto one SDRAM Wishbone port.
// Latency: strobe in cycle 0 -> m_stb_o cycle 1 -> req_ack_o one cycle after m_ack_i; masters hold req_stb_i until acked, timeout aborts with req_err_o.
module sdram_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_stb_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic                      req_err_o,
  output logic [DATA_W-1:0]         req_dat_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      m_stb_o,
  output logic                      m_we_o,
  output logic [ADDR_W-1:0]         m_addr_o,
  output logic [DATA_W-1:0]         m_dat_o,
  input  logic [DATA_W-1:0]         m_dat_i,
  input  logic                      m_ack_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx;
  logic             pick_vld;
  logic [CNT_W-1:0] cnt;
  int               sum;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] dat_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    assign dat_arr[g]  = req_dat_i[g*DATA_W +: DATA_W];
  end

  // First set strobe scanning upward from the one after the last winner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    sum      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IDX_W'(sum);
      if (!pick_vld && req_stb_i[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last      <= IDX_W'(NUM_REQ - 1);
      owner     <= '0;
      cnt       <= '0;
      req_ack_o <= '0;
      req_err_o <= 1'b0;
      req_dat_o <= '0;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_addr_o  <= '0;
      m_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner    <= pick;
            grant_o  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            m_we_o   <= req_we_i[pick];
            m_addr_o <= addr_arr[pick];
            m_dat_o  <= dat_arr[pick];
            m_stb_o  <= 1'b1;
            busy_o   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          m_stb_o <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (m_ack_i) begin
            if (!m_we_o) req_dat_o <= m_dat_i;
            req_ack_o <= grant_o;
            req_err_o <= 1'b0;
            state     <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Abort: read data register keeps its previous contents.
            req_ack_o <= grant_o;
            req_err_o <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          req_ack_o <= '0;
          req_err_o <= 1'b0;
          grant_o   <= '0;
          busy_o    <= 1'b0;
          last      <= owner;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Bench for sdram_wb_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_sdram_wb_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 16;
  localparam int TO   = 8;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      stb;
  logic [NREQ-1:0]      we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdat;
  logic                 m_ack;
  logic [DW-1:0]        m_rdat;

  logic [NREQ-1:0]      req_ack_o;
  logic                 req_err_o;
  logic [DW-1:0]        req_dat_o;
  logic [NREQ-1:0]      grant_o;
  logic                 busy_o;
  logic                 m_stb_o;
  logic                 m_we_o;
  logic [AW-1:0]        m_addr_o;
  logic [DW-1:0]        m_dat_o;

  int n_vec  = 0;
  int n_fail = 0;
  int pend   = 0;

  sdram_wb_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_stb_i(stb), .req_we_i(we), .req_addr_i(addr), .req_dat_i(wdat),
    .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_dat_o(req_dat_o),
    .grant_o(grant_o), .busy_o(busy_o),
    .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_dat_o(m_dat_o),
    .m_dat_i(m_rdat), .m_ack_i(m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is: granted (issue cycle, age 0), then waiting ages 1..TO,
  // then one response cycle. Ack is honoured only while waiting.
  logic           md_ok = 1'b0;
  logic           md_busy = 1'b0, md_resp = 1'b0, md_to = 1'b0;
  int             md_owner = 0, md_age = 0, md_last = NREQ - 1;
  logic           md_we = 1'b0;
  logic [AW-1:0]  md_addr = '0;
  logic [DW-1:0]  md_wdat = '0, md_rdat = '0;

  function automatic int rr_pick(input int lst, input logic [NREQ-1:0] s);
    for (int k = 1; k <= NREQ; k++)
      if (s[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdat_of(input int i);
    return wdat[i*DW +: DW];
  endfunction

  always @(negedge clk) begin
    if (md_ok) begin
      chk("grant",   grant_o,   md_busy ? 4'(1 << md_owner) : 4'b0);
      chk("busy",    busy_o,    md_busy);
      chk("m_stb",   m_stb_o,   md_busy && !md_resp && md_age == 0);
      chk("req_ack", req_ack_o, md_resp ? 4'(1 << md_owner) : 4'b0);
      chk("req_err", req_err_o, md_resp && md_to);
      chk("req_dat", req_dat_o, md_rdat);
      chk("m_we",    m_we_o,    md_we);
      chk("m_addr",  m_addr_o,  md_addr);
      chk("m_dat",   m_dat_o,   md_wdat);
    end
    if (rst) begin
      md_ok <= 1'b1; md_busy <= 1'b0; md_resp <= 1'b0; md_to <= 1'b0;
      md_last <= NREQ - 1; md_age <= 0; md_owner <= 0;
      md_we <= 1'b0; md_addr <= '0; md_wdat <= '0; md_rdat <= '0;
    end else if (md_ok) begin
      if (!md_busy) begin
        if (stb != '0) begin
          md_busy  <= 1'b1;
          md_age   <= 0;
          md_owner <= rr_pick(md_last, stb);
          md_we    <= we[rr_pick(md_last, stb)];
          md_addr  <= addr_of(rr_pick(md_last, stb));
          md_wdat  <= wdat_of(rr_pick(md_last, stb));
        end
      end else if (md_resp) begin
        md_busy <= 1'b0; md_resp <= 1'b0; md_to <= 1'b0; md_last <= md_owner;
      end else if (md_age == 0) begin
        md_age <= 1;
      end else if (m_ack) begin
        md_resp <= 1'b1; md_to <= 1'b0;
        if (!md_we) md_rdat <= m_rdat;
      end else if (md_age == TO) begin
        md_resp <= 1'b1; md_to <= 1'b1;
      end else begin
        md_age <= md_age + 1;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse;
    rst = 1'b1; tick; rst = 1'b0;
  endtask

  // Ends at the negedge of the issue cycle (bounded wait).
  task automatic wait_issue;
    int n;
    n = 0;
    @(negedge clk);
    while (!m_stb_o && n < 16) begin @(negedge clk); n++; end
    chk("issue_seen", m_stb_o, 1'b1);
  endtask

  // lat = WAIT cycle carrying m_ack_i (0 = never, expect timeout).
  task automatic do_txn(input int lat, input logic [DW-1:0] rd, input logic [NREQ-1:0] g,
                        input logic [NREQ-1:0] drop, input logic we_e, input logic [AW-1:0] a_e,
                        input logic [DW-1:0] d_e, input logic [DW-1:0] rd_e);
    int nw;
    wait_issue;
    chk("issue_grant", grant_o, g);
    chk("issue_we", m_we_o, we_e);
    chk("issue_addr", m_addr_o, a_e);
    chk("issue_wdat", m_dat_o, d_e);
    nw = (lat > 0) ? lat : TO;
    for (int i = 1; i <= nw; i++) begin
      tick;
      if (i == lat) begin m_ack = 1'b1; m_rdat = rd; end
    end
    tick;
    m_ack = 1'b0;
    stb = stb & ~drop;
    @(negedge clk);
    chk("resp_ack", req_ack_o, g);
    chk("resp_err", req_err_o, lat == 0);
    chk("resp_rdat", req_dat_o, rd_e);
    chk("resp_we", m_we_o, we_e);
    chk("resp_addr", m_addr_o, a_e);
    chk("resp_wdat", m_dat_o, d_e);
    tick;
    @(negedge clk);
    chk("ack_one_cycle", req_ack_o, 4'b0);
    chk("idle_grant", grant_o, 4'b0);
    chk("idle_busy", busy_o, 1'b0);
    tick;
  endtask

  initial begin
    rst = 1'b1; stb = '0; we = '0; wdat = '0; m_ack = 1'b0; m_rdat = '0;
    addr = '0;
    addr[0*AW +: AW] = 32'h0000_1000;
    addr[1*AW +: AW] = 32'h0000_2000;
    addr[2*AW +: AW] = 32'h0000_0100;
    addr[3*AW +: AW] = 32'h0000_3000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_grant", grant_o, 4'b0);
    chk("rst_stb", m_stb_o, 1'b0);
    chk("rst_ack", req_ack_o, 4'b0);
    chk("rst_rdat", req_dat_o, 16'h0);
    tick;

    // single read by requester 2, ack 3 cycles after strobe
    stb[2] = 1'b1;
    do_txn(3, 16'hBEEF, 4'b0100, 4'b0100, 1'b0, 32'h100, 16'h0, 16'hBEEF);

    // 0,1,3 simultaneous after reset -> 0,1,3
    rst_pulse;
    stb = 4'b1011;
    do_txn(1, 16'h1111, 4'b0001, 4'b0001, 1'b0, 32'h1000, 16'h0, 16'h1111);
    do_txn(1, 16'h2222, 4'b0010, 4'b0010, 1'b0, 32'h2000, 16'h0, 16'h2222);
    do_txn(1, 16'h3333, 4'b1000, 4'b1000, 1'b0, 32'h3000, 16'h0, 16'h3333);

    // write by requester 1 leaves read data alone
    we[1] = 1'b1; wdat[1*DW +: DW] = 16'h1234; stb[1] = 1'b1;
    do_txn(2, 16'hDEAD, 4'b0010, 4'b0010, 1'b1, 32'h2000, 16'h1234, 16'h3333);
    we = '0; wdat = '0;

    // requester 0 never lets go, requester 1 still gets every other slot
    rst_pulse;
    stb = 4'b0011;
    do_txn(1, 16'hA101, 4'b0001, 4'b0000, 1'b0, 32'h1000, 16'h0, 16'hA101);
    do_txn(1, 16'hA102, 4'b0010, 4'b0000, 1'b0, 32'h2000, 16'h0, 16'hA102);
    do_txn(1, 16'hA103, 4'b0001, 4'b0000, 1'b0, 32'h1000, 16'h0, 16'hA103);
    do_txn(1, 16'hA104, 4'b0010, 4'b0011, 1'b0, 32'h2000, 16'h0, 16'hA104);

    // timeout, then a late ack that must be ignored, then a normal write
    rst_pulse;
    stb[2] = 1'b1;
    do_txn(0, 16'h0, 4'b0100, 4'b0100, 1'b0, 32'h100, 16'h0, 16'h0);
    m_ack = 1'b1; m_rdat = 16'hFFFF;
    @(negedge clk);
    chk("stray_busy", busy_o, 1'b0);
    tick;
    m_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack", req_ack_o, 4'b0);
    chk("stray_rdat", req_dat_o, 16'h0);
    tick;
    we[3] = 1'b1; wdat[3*DW +: DW] = 16'hCAFE; stb[3] = 1'b1;
    do_txn(1, 16'h0, 4'b1000, 4'b1000, 1'b1, 32'h3000, 16'hCAFE, 16'h0);

    // reset during WAIT with an ack arriving at the same time
    we = '0; wdat = '0;
    stb[3] = 1'b1;
    wait_issue;
    tick;
    tick;
    rst = 1'b1; m_ack = 1'b1; m_rdat = 16'h7777;
    tick;
    rst = 1'b0; stb[0] = 1'b1;
    @(negedge clk);
    chk("wrst_busy", busy_o, 1'b0);
    chk("wrst_grant", grant_o, 4'b0);
    chk("wrst_ack", req_ack_o, 4'b0);
    chk("wrst_addr", m_addr_o, 32'h0);
    chk("wrst_rdat", req_dat_o, 16'h0);
    tick;
    m_ack = 1'b0;
    do_txn(1, 16'h5A5A, 4'b0001, 4'b0001, 1'b0, 32'h1000, 16'h0, 16'h5A5A);
    do_txn(1, 16'h6B6B, 4'b1000, 4'b1000, 1'b0, 32'h3000, 16'h0, 16'h6B6B);

    // randomized traffic: masters, random-latency slave, stray acks, occasional reset
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack_o[i]) stb[i] = 1'($urandom_range(0, 1));
        else if (!stb[i]) stb[i] = ($urandom_range(0, 3) == 0);
      end
      we = 4'($urandom);
      addr = {$urandom, $urandom, $urandom, $urandom};
      wdat = {$urandom, $urandom};
      m_rdat = 16'($urandom);
      m_ack = 1'b0;
      if (m_stb_o) pend = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 4));
      else if (pend > 0) begin
        pend--;
        if (pend == 0) m_ack = 1'b1;
      end else if (pend == 0 && $urandom_range(0, 19) == 0) m_ack = 1'b1;
      if (rst) pend = 0;
    end
    rst = 1'b0; m_ack = 1'b0; stb = '0;
    repeat (3) tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
